proc_monitor: RTL and testbench
===============================

# proc_monitor

Run-control and health monitor sitting directly downstream of the processor core in the top-level hierarchy. It consumes the core's `err`, `halt` and per-instruction commit strobe, and counts cycles and retired instructions. It detects error, halt and hang conditions, lets the pipeline drain after `halt`, and then freezes the core through `run_en`. It also produces sticky `done`/`fail` status for the clock/reset generator and the bench.

## Interface
- `WDOG_CYCLES`, default 1024: consecutive commit-free cycles in RUN that trigger a hang failure; 0 disables the watchdog.
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN after `halt` before `done`; 0 means go straight to DONE.
- `MAX_CYCLES`, default 32'd1_000_000: absolute cycle limit; used only under `PROC_MON_MAXCYC_EN`.
- `clk` in 1: single clock, shared with the core.
- `rst` in 1: synchronous, active-high reset.
- `err` in 1: core error flag, sampled every cycle.
- `halt` in 1: core has decoded HALT; a one-cycle pulse or a level.
- `commit` in 1: one instruction retired this cycle.
- `run_en` out 1: core may advance. Reset value 1.
- `done` out 1: sticky clean completion. Reset value 0.
- `fail` out 1: sticky failure. Reset value 0.
- `fail_code` out 2: 0 none, 1 core err, 2 watchdog, 3 max-cycle. Reset value 0.
- `cycle_count` out 32: cycles spent in RUN+DRAIN. Reset value 0.
- `instr_count` out 32: commits counted. Reset value 0.

## Operation
- FSM states are RUN, DRAIN, DONE and FAIL. The reset state is RUN.
- `run_en` = 1 in RUN and DRAIN, 0 in DONE and FAIL. It is decoded directly from the state register.
- Transitions out of RUN, evaluated in this priority order:
  - `err` → FAIL, code 1.
  - `halt` → DRAIN, or → DONE if `DRAIN_CYCLES` = 0.
  - Watchdog expiry → FAIL, code 2.
  - Max-cycle hit → FAIL, code 3.
- DRAIN:
  - `err` → FAIL, code 1.
  - Otherwise the drain counter decrements; DRAIN → DONE in the cycle the counter equals 1.
  - Further `halt` pulses are ignored.
  - The watchdog does not run in DRAIN.
- DONE and FAIL are terminal until `rst`. `err` arriving after DONE is ignored, so `done` never changes to `fail`.
- `err` and `halt` in the same cycle resolve to FAIL, code 1.
- Counters:
  - `cycle_count` increments every cycle in RUN or DRAIN and holds in DONE/FAIL.
  - `instr_count` increments on `commit` in RUN or DRAIN and holds in DONE/FAIL.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Watchdog:
  - The idle counter clears on `commit` and on entry to RUN, and increments otherwise.
  - It expires when the idle counter = `WDOG_CYCLES`−1 and `commit` = 0.
- `rst` mid-operation, in any state, returns the block to RUN with all outputs at their reset values on the next edge.

## Timing
- Every status output is registered, so each transition is visible one cycle after the triggering input is sampled.
- `halt` sampled at edge N:
  - DRAIN is entered at N+1.
  - `done`=1 and `run_en`=0 at N+1+`DRAIN_CYCLES`.
- `err` sampled at edge N: `fail`=1 and `run_en`=0 at N+1.
- A `commit` in the same cycle as the transition into DONE/FAIL is still counted.
- Watchdog: with no commits after reset, `fail` asserts `WDOG_CYCLES` cycles after `rst` deasserts.

## Configuration
- `PROC_MON_MAXCYC_EN` defined:
  - A comparator against `MAX_CYCLES` is compiled in.
  - In RUN, `cycle_count` = `MAX_CYCLES`−1 → FAIL, code 3.
- `PROC_MON_MAXCYC_EN` undefined: no comparator is compiled in, and code 3 is never produced.

## Structure
- `proc_mon_pkg` holds:
  - The FSM state encoding.
  - The `fail_code` localparams (FC_NONE, FC_ERR, FC_WDOG, FC_MAXCYC).
  - The counter width constant (32).
- Sub-module `sat_counter`: parameterised width, with clear, enable and saturate-at-max. It is instantiated for `cycle_count`, `instr_count` and the watchdog idle counter.
- The drain counter is inline.

## Test plan
- Reset, then 10 commits, then a `halt` pulse with `DRAIN_CYCLES`=4:
  - `done`=1 exactly 5 cycles after `halt` is sampled.
  - `instr_count`=10, `fail`=0, `run_en`=0.
- `err` pulse in cycle 20 of RUN: at cycle 21, `fail`=1, `fail_code`=1, `run_en`=0, and `cycle_count` holds at 20.
- `err` and `halt` in the same cycle → FAIL code 1, `done` stays 0. In a separate run, `err` 3 cycles after DONE → `done` stays 1, `fail` stays 0.
- `WDOG_CYCLES`=16 with no commits after reset:
  - `fail`=1 with code 2 after 16 cycles.
  - A commit every 15 cycles never trips the watchdog.
- With `PROC_MON_MAXCYC_EN` and `MAX_CYCLES`=50, continuous commits: FAIL code 3, `cycle_count`=50. Without the macro, the same stimulus keeps running past 50 cycles.
- Assert `rst` for 1 cycle while in DRAIN: outputs return to their reset values, the state is RUN, the counters are 0, and a subsequent halt completes normally.

Source files
------------

// File: rtl/proc_mon_pkg.sv
// proc_mon_pkg
//   Shared definitions for the proc_monitor run-control block: the FSM state
//   encoding, the fail_code values and the width of the status counters.
package proc_mon_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_ERR    = 2'd1;
  localparam logic [1:0] FC_WDOG   = 2'd2;
  localparam logic [1:0] FC_MAXCYC = 2'd3;

endpackage

// File: rtl/proc_monitor_sat_counter.sv
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset, clears the count
//     clr  - synchronous clear, same effect as rst
//     en   - count enable
//     q    - current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && (q != MAX)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/proc_monitor.sv
// proc_monitor
//   Run-control and health monitor downstream of the processor core. Counts
//   cycles and retired instructions, detects error, halt and hang, lets the
//   pipeline drain after halt and then freezes the core via run_en.
//   Optional feature: define PROC_MON_MAXCYC_EN to compile in an absolute
//   cycle limit (MAX_CYCLES) that fails the run with code 3.
//   Ports:
//     clk, rst     - clock and synchronous active-high reset
//     err          - core error flag
//     halt         - core decoded HALT (pulse or level)
//     commit       - one instruction retired this cycle
//     run_en       - core may advance (high in RUN and DRAIN)
//     done, fail   - sticky completion / failure status
//     fail_code    - 0 none, 1 core err, 2 watchdog, 3 max-cycle
//     cycle_count  - cycles spent in RUN+DRAIN (saturating)
//     instr_count  - commits counted in RUN+DRAIN (saturating)
module proc_monitor
  import proc_mon_pkg::*;
#(
  parameter int unsigned      WDOG_CYCLES  = 1024,
  parameter int unsigned      DRAIN_CYCLES = 4,
  parameter logic [CNT_W-1:0] MAX_CYCLES   = 32'd1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err,
  input  logic             halt,
  input  logic             commit,
  output logic             run_en,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [31:0]      DRAIN_LOAD = 32'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(WDOG_CYCLES - 1);

  state_t           state, state_n;
  logic [31:0]      drain_cnt, drain_n;
  logic [1:0]       code_n;
  logic [CNT_W-1:0] idle_count;
  logic             in_run;
  logic             wdog_hit;
  logic             maxcyc_hit;

  assign in_run = (state == S_RUN);
  assign run_en = (state == S_RUN) || (state == S_DRAIN);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (run_en),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (run_en && commit),
    .q   (instr_count)
  );

  // Idle counter is held at zero outside RUN so it starts fresh whenever
  // RUN is (re)entered, which only happens through reset.
  sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (commit || !in_run),
    .en  (in_run),
    .q   (idle_count)
  );

  always_comb begin
    wdog_hit = (WDOG_CYCLES != 0) && (idle_count == WDOG_LAST) && !commit;
`ifdef PROC_MON_MAXCYC_EN
    maxcyc_hit = (cycle_count == (MAX_CYCLES - 32'd1));
`else
    maxcyc_hit = 1'b0;
`endif
  end

  // Next-state logic. err always wins, so err+halt together is a failure.
  // DONE and FAIL hold until reset.
  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    code_n  = fail_code;
    case (state)
      S_RUN: begin
        if (err) begin
          state_n = S_FAIL;
          code_n  = FC_ERR;
        end else if (halt) begin
          if (DRAIN_CYCLES == 0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_DRAIN;
            drain_n = DRAIN_LOAD;
          end
        end else if (wdog_hit) begin
          state_n = S_FAIL;
          code_n  = FC_WDOG;
        end else if (maxcyc_hit) begin
          state_n = S_FAIL;
          code_n  = FC_MAXCYC;
        end
      end
      S_DRAIN: begin
        if (err) begin
          state_n = S_FAIL;
          code_n  = FC_ERR;
        end else if (drain_cnt == 32'd1) begin
          state_n = S_DONE;
        end else begin
          drain_n = drain_cnt - 32'd1;
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  // done/fail are registered from the next state so they appear together
  // with the state change and never disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      fail_code <= FC_NONE;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
      fail_code <= code_n;
      done      <= (state_n == S_DONE);
      fail      <= (state_n == S_FAIL);
    end
  end

endmodule

// File: tb/tb_proc_monitor.sv
// tb_proc_monitor
//   Directed testbench for proc_monitor. Three instances share the stimulus:
//   dut (defaults, MAX_CYCLES=50), dutw (WDOG_CYCLES=16) and dutz
//   (DRAIN_CYCLES=0). Each check only looks at the instance it concerns.
module tb_proc_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err = 1'b0;
  logic halt = 1'b0;
  logic commit = 1'b0;

  logic        runEn, done, fail;
  logic [1:0]  failCode;
  logic [31:0] cycleCount, instrCount;

  logic        runEnW, doneW, failW;
  logic [1:0]  failCodeW;
  logic [31:0] cycleCountW, instrCountW;

  logic        runEnZ, doneZ, failZ;
  logic [1:0]  failCodeZ;
  logic [31:0] cycleCountZ, instrCountZ;

  int testsRun = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  proc_monitor #(.WDOG_CYCLES(1024), .DRAIN_CYCLES(4), .MAX_CYCLES(32'd50)) dut (
    .clk(clk), .rst(rst), .err(err), .halt(halt), .commit(commit),
    .run_en(runEn), .done(done), .fail(fail), .fail_code(failCode),
    .cycle_count(cycleCount), .instr_count(instrCount)
  );

  proc_monitor #(.WDOG_CYCLES(16), .DRAIN_CYCLES(4)) dutw (
    .clk(clk), .rst(rst), .err(err), .halt(halt), .commit(commit),
    .run_en(runEnW), .done(doneW), .fail(failW), .fail_code(failCodeW),
    .cycle_count(cycleCountW), .instr_count(instrCountW)
  );

  proc_monitor #(.WDOG_CYCLES(1024), .DRAIN_CYCLES(0)) dutz (
    .clk(clk), .rst(rst), .err(err), .halt(halt), .commit(commit),
    .run_en(runEnZ), .done(doneZ), .fail(failZ), .fail_code(failCodeZ),
    .cycle_count(cycleCountZ), .instr_count(instrCountZ)
  );

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic e, input logic h, input logic c);
    err    = e;
    halt   = h;
    commit = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset values
    doReset();
    checkOutput("rst run_en", 32'(runEn), 32'd1);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst fail", 32'(fail), 32'd0);
    checkOutput("rst fail_code", 32'(failCode), 32'd0);
    checkOutput("rst cycle_count", cycleCount, 32'd0);
    checkOutput("rst instr_count", instrCount, 32'd0);

    // 10 commits, halt pulse, 4-cycle drain; zero-drain instance finishes at once
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("commit instr_count", instrCount, 32'd10);
    checkOutput("commit cycle_count", cycleCount, 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("drain run_en", 32'(runEn), 32'd1);
    checkOutput("drain done", 32'(done), 32'd0);
    checkOutput("zero-drain done", 32'(doneZ), 32'd1);
    checkOutput("zero-drain run_en", 32'(runEnZ), 32'd0);
    checkOutput("zero-drain instr", instrCountZ, 32'd10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("drain done early", 32'(done), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("halt done", 32'(done), 32'd1);
    checkOutput("halt run_en", 32'(runEn), 32'd0);
    checkOutput("halt fail", 32'(fail), 32'd0);
    checkOutput("halt instr_count", instrCount, 32'd10);
    checkOutput("halt cycle_count", cycleCount, 32'd15);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("err after done: done", 32'(done), 32'd1);
    checkOutput("err after done: fail", 32'(fail), 32'd0);
    checkOutput("done cycle hold", cycleCount, 32'd15);
    checkOutput("done instr hold", instrCount, 32'd10);

    // err in cycle 20 of RUN, with a commit in the same cycle
    doReset();
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("err fail", 32'(fail), 32'd1);
    checkOutput("err fail_code", 32'(failCode), 32'd1);
    checkOutput("err run_en", 32'(runEn), 32'd0);
    checkOutput("err cycle_count", cycleCount, 32'd20);
    checkOutput("err instr_count", instrCount, 32'd20);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("fail cycle hold", cycleCount, 32'd20);
    checkOutput("fail instr hold", instrCount, 32'd20);

    // err and halt together
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("err+halt fail", 32'(fail), 32'd1);
    checkOutput("err+halt code", 32'(failCode), 32'd1);
    checkOutput("err+halt done", 32'(done), 32'd0);
    checkOutput("err+halt zero-drain done", 32'(doneZ), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("err+halt done later", 32'(done), 32'd0);

    // Watchdog, 16 commit-free cycles
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wdog not yet", 32'(failW), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wdog fail", 32'(failW), 32'd1);
    checkOutput("wdog code", 32'(failCodeW), 32'd2);
    checkOutput("wdog run_en", 32'(runEnW), 32'd0);
    checkOutput("wdog cycle_count", cycleCountW, 32'd16);
    checkOutput("wdog 1024 quiet", 32'(fail), 32'd0);

    // A commit every 15 cycles keeps the watchdog quiet
    doReset();
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, (i % 15) == 14);
    checkOutput("wdog kept fail", 32'(failW), 32'd0);
    checkOutput("wdog kept run_en", 32'(runEnW), 32'd1);
    checkOutput("wdog kept instr", instrCountW, 32'd6);
    checkOutput("wdog kept cycle", cycleCountW, 32'd100);

    // Max-cycle limit with continuous commits
    doReset();
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef PROC_MON_MAXCYC_EN
    checkOutput("maxcyc fail", 32'(fail), 32'd1);
    checkOutput("maxcyc code", 32'(failCode), 32'd3);
    checkOutput("maxcyc cycle_count", cycleCount, 32'd50);
    checkOutput("maxcyc instr_count", instrCount, 32'd50);
`else
    checkOutput("no maxcyc fail", 32'(fail), 32'd0);
    checkOutput("no maxcyc run_en", 32'(runEn), 32'd1);
    checkOutput("no maxcyc cycle_count", cycleCount, 32'd60);
`endif

    // Reset while draining, then a normal halt
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    doReset();
    checkOutput("mid rst run_en", 32'(runEn), 32'd1);
    checkOutput("mid rst done", 32'(done), 32'd0);
    checkOutput("mid rst fail", 32'(fail), 32'd0);
    checkOutput("mid rst code", 32'(failCode), 32'd0);
    checkOutput("mid rst cycle", cycleCount, 32'd0);
    checkOutput("mid rst instr", instrCount, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post rst drain", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post rst done", 32'(done), 32'd1);
    checkOutput("post rst cycle", cycleCount, 32'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
